spi_crc_check: RTL and testbench
================================

# spi_crc_check

Receive-side CRC checker for the SPI execution unit. It consumes a frame of WCODE-bit data beats, then one CRC beat, from the SPI receive path. It computes the running MSB-first CRC remainder over the data beats and compares it against the received CRC field. The result goes to the SPI control FSM as a one-cycle done strobe plus a held pass/fail flag. It is the checking counterpart of the transmit-side CRC generator.

## Interface
- WCODE, 4, data beat width in bits
- WPOLY, 4, generator width including implicit top term; CRC field width P = WPOLY-1; requires P <= WCODE
- MAXLEN, 16, maximum data beats per frame; LW = $clog2(MAXLEN+1)
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset; one clock; asynchronous, active-low
- i_start  in  1  frame start pulse; honoured only in IDLE
- i_len  in  LW  data beats in the frame (0..MAXLEN); latched on accepted i_start
- i_poly  in  WPOLY  generator; i_poly[WPOLY-1] must be 1; latched on accepted i_start
- i_abort  in  1  return to IDLE from any state; no done strobe
- i_valid  in  1  beat valid
- i_data  in  WCODE  beat payload
- o_ready  out  1  beat accepted when i_valid && o_ready
- o_busy  out  1  state != IDLE
- o_done  out  1  one-cycle strobe: frame check complete
- o_crc_ok  out  1  1 = received CRC matched; held until next accepted i_start
- o_crc  out  P  computed remainder; held until next accepted i_start

## Operation
- Remainder r (P bits) is cleared to 0 on accepted i_start. There is no final XOR and no bit reflection.
- Per data beat, the bits of i_data are processed MSB first. For each bit b: fb = r[P-1]^b; r = {r[P-2:0],1'b0} ^ (fb ? poly[P-1:0] : 0). All WCODE bits are processed in one cycle.
- CRC beat: the received field is i_data[P-1:0]. Pass requires i_data[P-1:0] == r and i_data[WCODE-1:P] == 0 (unused bits must be zero).
- States:
  - IDLE: o_ready=0. On i_start, go to DATA with cnt=i_len if i_len != 0, else go to CRC. Also clear o_crc_ok and o_crc, and set r=0.
  - DATA: o_ready=1. On each accepted beat, update r and decrement cnt. On the beat with cnt==1, go to CRC.
  - CRC: o_ready=1. On the accepted beat, register o_crc_ok, set o_crc=r, and go to DONE.
  - DONE: o_done=1, o_ready=0; return to IDLE next cycle.
- i_abort has priority over every other event, including a simultaneous i_start or accepted beat. It forces IDLE, keeps o_crc_ok and o_crc unchanged, and produces no o_done.
- i_start outside IDLE is ignored.
- i_len > MAXLEN is clamped to MAXLEN.
- A beat with i_valid=0 causes no change; stalls of any length are allowed.

## Timing
- Reset: state=IDLE; o_ready, o_busy, o_done, o_crc_ok = 0; o_crc = 0; r = 0; cnt = 0.
- o_ready, o_busy and o_done decode directly from registered state (no combinational path from inputs).
- First beat can be accepted the cycle after the accepted i_start.
- o_done asserts exactly one cycle after the CRC beat is accepted; o_crc_ok and o_crc are valid in that same cycle.
- A new i_start is accepted no earlier than the cycle after o_done (IDLE).
- Minimum frame time at full throughput: i_len + 3 cycles (start through done).
- Reset mid-frame: immediate return to reset values; the partial frame is discarded.

## Structure
- Package spi_crc_pkg: state enum (IDLE, DATA, CRC, DONE) and a localparam helper for LW.
- Sub-module crc_nibble_step: purely combinational; inputs r, data, poly; output next r per the rule above. It is shared with the transmit-side generator.
- Top holds the FSM, the beat counter, and the r, poly, o_crc and o_crc_ok registers.

## Test plan
- poly=4'b1011, len=1, beats 4'hD then 4'h1 -> o_done one cycle after the CRC beat, o_crc=3'b001, o_crc_ok=1.
- Same poly, len=2, beats 4'hD, 4'h5, 4'h2 -> o_crc=3'b010, o_crc_ok=1. Repeat with CRC beat 4'h3 -> o_crc_ok=0.
- Same as the first case but CRC beat 4'h9 (nonzero unused bit) -> o_crc_ok=0, o_crc=3'b001.
- len=0, single beat 4'h0 -> o_crc_ok=1. Single beat 4'h4 instead -> o_crc_ok=0.
- len=2 with i_valid deasserted 5 cycles between beats, i_start pulsed mid-frame -> i_start ignored, same result as the gapless run.
- i_abort with the second data beat (and, in a separate run, i_rst_n low mid-frame) -> IDLE next cycle, no o_done. o_crc_ok and o_crc keep their prior values on abort and read 0 after reset. A following frame checks correctly.

Source files
------------

// File: rtl/spi_crc_pkg.sv
// Shared types and helpers for the SPI receive-side CRC checker and its
// transmit-side counterpart.
package spi_crc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Width of a counter that must hold 0..maxlen inclusive.
  function automatic int len_width(input int maxlen);
    return $clog2(maxlen + 1);
  endfunction

endpackage

// File: rtl/crc_nibble_step.sv
// One beat of MSB-first CRC division: folds all WCODE data bits into the
// running P-bit remainder in a single combinational step.
module crc_nibble_step #(
  parameter int WCODE = 4,
  parameter int WPOLY = 4
) (
  input  logic [WPOLY-2:0] r_i,
  input  logic [WCODE-1:0] data_i,
  input  logic [WPOLY-2:0] poly_i,
  output logic [WPOLY-2:0] r_o
);

  localparam int P = WPOLY - 1;

  logic [P-1:0] r;
  logic         fb;

  // poly_i carries only the low P terms; the top term is implied by the shift.
  always_comb begin
    r  = r_i;
    fb = 1'b0;
    for (int i = WCODE - 1; i >= 0; i--) begin
      fb = r[P-1] ^ data_i[i];
      r  = (r << 1) ^ (fb ? poly_i : '0);
    end
    r_o = r;
  end

endmodule

// File: rtl/spi_crc_check.sv
// Receive-side CRC checker: accumulates the remainder over a frame of data
// beats, then compares it against the trailing CRC beat.
module spi_crc_check
  import spi_crc_pkg::*;
#(
  parameter int WCODE  = 4,
  parameter int WPOLY  = 4,
  parameter int MAXLEN = 16,
  parameter int LW     = len_width(MAXLEN)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [LW-1:0]    i_len,
  input  logic [WPOLY-1:0] i_poly,
  input  logic             i_abort,
  input  logic             i_valid,
  input  logic [WCODE-1:0] i_data,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_crc_ok,
  output logic [WPOLY-2:0] o_crc
);

  localparam int P = WPOLY - 1;

  function automatic logic [LW-1:0] sat_len(input logic [LW-1:0] len);
    if (len > LW'(MAXLEN)) return LW'(MAXLEN);
    return len;
  endfunction

  state_e        state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [P-1:0]  r_q, r_d;
  logic [P-1:0]  poly_q, poly_d;
  logic [P-1:0]  crc_q, crc_d;
  logic          ok_q, ok_d;

  logic [P-1:0]  r_step;
  logic [LW-1:0] len_sat;
  logic          ready;
  logic          beat;
  logic          crc_match;
  logic          unused_poly_msb;

  // The generator's top term is always 1 and never enters the arithmetic.
  assign unused_poly_msb = i_poly[WPOLY-1];

  assign len_sat   = sat_len(i_len);
  assign ready     = (state_q == DATA) || (state_q == CRC);
  assign beat      = i_valid && ready;
  assign crc_match = (i_data == WCODE'(r_q));

  crc_nibble_step #(
    .WCODE (WCODE),
    .WPOLY (WPOLY)
  ) u_step (
    .r_i    (r_q),
    .data_i (i_data),
    .poly_i (poly_q),
    .r_o    (r_step)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      poly_q  <= '0;
      crc_q   <= '0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      poly_q  <= poly_d;
      crc_q   <= crc_d;
      ok_q    <= ok_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    poly_d  = poly_q;
    crc_d   = crc_q;
    ok_d    = ok_q;
    // Abort wins over start and beats alike, and leaves the result untouched.
    if (i_abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            r_d    = '0;
            poly_d = i_poly[P-1:0];
            ok_d   = 1'b0;
            crc_d  = '0;
            cnt_d  = len_sat;
            state_d = (len_sat != '0) ? DATA : CRC;
          end
        end
        DATA: begin
          if (beat) begin
            r_d   = r_step;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == LW'(1)) state_d = CRC;
          end
        end
        CRC: begin
          if (beat) begin
            ok_d    = crc_match;
            crc_d   = r_q;
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign o_ready  = ready;
  assign o_busy   = (state_q != IDLE);
  assign o_done   = (state_q == DONE);
  assign o_crc_ok = ok_q;
  assign o_crc    = crc_q;

endmodule

// File: tb/tb_spi_crc_check.sv
// Bench for spi_crc_check: directed frames with literal expectations plus a
// polynomial-division reference model compared on every cycle.
module tb_spi_crc_check;

  localparam int WCODE  = 4;
  localparam int WPOLY  = 4;
  localparam int MAXLEN = 16;
  localparam int P      = WPOLY - 1;
  localparam int LW     = $clog2(MAXLEN + 1);

  logic             i_clk   = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_start = 1'b0;
  logic [LW-1:0]    i_len   = '0;
  logic [WPOLY-1:0] i_poly  = 4'b1011;
  logic             i_abort = 1'b0;
  logic             i_valid = 1'b0;
  logic [WCODE-1:0] i_data  = '0;
  logic             o_ready, o_busy, o_done, o_crc_ok;
  logic [P-1:0]     o_crc;

  int errors = 0;
  int checks = 0;

  spi_crc_check #(.WCODE(WCODE), .WPOLY(WPOLY), .MAXLEN(MAXLEN)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (i_start),
    .i_len    (i_len),
    .i_poly   (i_poly),
    .i_abort  (i_abort),
    .i_valid  (i_valid),
    .i_data   (i_data),
    .o_ready  (o_ready),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_crc_ok (o_crc_ok),
    .o_crc    (o_crc)
  );

  always #5 i_clk = ~i_clk;

  // Reference: remainder of M(x)*x^P divided by G(x), by textbook long division.
  function automatic logic [P-1:0] crc_div(input logic [WCODE-1:0] msg[$], input logic [WPOLY-1:0] g);
    logic bits [0:MAXLEN*WCODE+WPOLY];
    logic [P-1:0] rem;
    int n;
    n = msg.size() * WCODE;
    for (int i = 0; i < n + P; i++)
      bits[i] = (i < n) ? msg[i / WCODE][WCODE - 1 - (i % WCODE)] : 1'b0;
    for (int i = 0; i < n; i++)
      if (bits[i])
        for (int j = 0; j < WPOLY; j++) bits[i + j] = bits[i + j] ^ g[WPOLY - 1 - j];
    for (int j = 0; j < P; j++) rem[P - 1 - j] = bits[n + j];
    return rem;
  endfunction

  // Frame-level model: 0 idle, 1 collecting data, 2 awaiting CRC beat, 3 done.
  int               m_mode = 0;
  int               m_left = 0;
  logic             m_ok   = 1'b0;
  logic [P-1:0]     m_crc  = '0;
  logic [WPOLY-1:0] m_poly = '0;
  logic [WCODE-1:0] m_q[$];

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_mode = 0; m_left = 0; m_ok = 1'b0; m_crc = '0; m_q.delete();
    end else if (i_abort) begin
      m_mode = 0;
    end else begin
      case (m_mode)
        0: if (i_start) begin
          m_q.delete();
          m_poly = i_poly;
          m_ok   = 1'b0;
          m_crc  = '0;
          m_left = (int'(i_len) > MAXLEN) ? MAXLEN : int'(i_len);
          m_mode = (m_left == 0) ? 2 : 1;
        end
        1: if (i_valid) begin
          m_q.push_back(i_data);
          m_left--;
          if (m_left == 0) m_mode = 2;
        end
        2: if (i_valid) begin
          m_crc  = crc_div(m_q, m_poly);
          m_ok   = (i_data == {{(WCODE-P){1'b0}}, m_crc});
          m_mode = 3;
        end
        default: m_mode = 0;
      endcase
    end
  end

  always @(negedge i_clk) begin
    logic [P+3:0] act, exp;
    act = {o_busy, o_ready, o_done, o_crc_ok, o_crc};
    exp = {m_mode != 0, (m_mode == 1) || (m_mode == 2), m_mode == 3, m_ok, m_crc};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cycle_model t=%0t: busy/ready/done/ok/crc got %b required %b", $time, act, exp);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic start_frame(input int len, input logic [WPOLY-1:0] poly);
    i_start = 1'b1;
    i_len   = LW'(len);
    i_poly  = poly;
    tick();
    i_start = 1'b0;
  endtask

  task automatic send_beat(input logic [WCODE-1:0] d);
    int w;
    w = 0;
    while (!o_ready && w < 50) begin
      tick();
      w++;
    end
    if (!o_ready) chk("ready_timeout", 32'(o_ready), 32'd1);
    i_valid = 1'b1;
    i_data  = d;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic run_frame(input string nm, input int len, input logic [WCODE-1:0] beats[$],
                           input logic [WCODE-1:0] crc_beat, input logic [P-1:0] exp_crc,
                           input logic exp_ok);
    start_frame(len, 4'b1011);
    foreach (beats[k]) send_beat(beats[k]);
    send_beat(crc_beat);
    chk({nm, "_done"}, 32'(o_done), 32'd1);
    chk({nm, "_crc"}, 32'(o_crc), 32'(exp_crc));
    chk({nm, "_ok"}, 32'(o_crc_ok), 32'(exp_ok));
    tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WCODE-1:0] bq[$];
    logic [WCODE-1:0] empty_q[$];
    logic [P-1:0]     ref_crc;
    int               dones;

    bq = '{4'hD};
    chk("model_D", 32'(crc_div(bq, 4'b1011)), 32'h1);
    bq = '{4'hD, 4'h5};
    chk("model_D5", 32'(crc_div(bq, 4'b1011)), 32'h2);

    repeat (3) tick();
    chk("reset_outs", 32'({o_busy, o_ready, o_done, o_crc_ok, o_crc}), 32'd0);
    i_rst_n = 1'b1;
    tick();

    bq = '{4'hD};
    run_frame("len1", 1, bq, 4'h1, 3'b001, 1'b1);
    bq = '{4'hD, 4'h5};
    run_frame("len2_pass", 2, bq, 4'h2, 3'b010, 1'b1);
    run_frame("len2_fail", 2, bq, 4'h3, 3'b010, 1'b0);
    bq = '{4'hD};
    run_frame("unused_bit", 1, bq, 4'h9, 3'b001, 1'b0);
    run_frame("len0_pass", 0, empty_q, 4'h0, 3'b000, 1'b1);
    run_frame("len0_fail", 0, empty_q, 4'h4, 3'b000, 1'b0);

    // Stalled frame with a stray start in the middle.
    start_frame(2, 4'b1011);
    send_beat(4'hD);
    for (int c = 0; c < 5; c++) begin
      i_start = (c == 2);
      i_len   = LW'(0);
      tick();
    end
    i_start = 1'b0;
    send_beat(4'h5);
    send_beat(4'h2);
    chk("gap_done", 32'(o_done), 32'd1);
    chk("gap_crc", 32'(o_crc), 32'h2);
    chk("gap_ok", 32'(o_crc_ok), 32'd1);
    tick();

    // Abort coinciding with the second data beat.
    start_frame(2, 4'b1011);
    send_beat(4'hD);
    i_valid = 1'b1; i_data = 4'h5; i_abort = 1'b1;
    tick();
    i_valid = 1'b0; i_abort = 1'b0;
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_hold", 32'({o_crc_ok, o_crc}), 32'd0);
    dones = 0;
    for (int c = 0; c < 4; c++) begin
      dones += int'(o_done);
      tick();
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    bq = '{4'hD};
    run_frame("after_abort", 1, bq, 4'h1, 3'b001, 1'b1);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    chk("idle_abort_hold", 32'({o_crc_ok, o_crc}), 32'({1'b1, 3'b001}));

    // Reset mid-frame.
    start_frame(2, 4'b1011);
    send_beat(4'hD);
    i_rst_n = 1'b0;
    #1;
    chk("midreset_outs", 32'({o_busy, o_ready, o_done, o_crc_ok, o_crc}), 32'd0);
    tick();
    i_rst_n = 1'b1;
    tick();
    bq = '{4'hD, 4'h5};
    run_frame("after_reset", 2, bq, 4'h2, 3'b010, 1'b1);

    // Oversized length saturates at MAXLEN beats.
    bq.delete();
    for (int k = 0; k < MAXLEN; k++) bq.push_back(WCODE'(k * 7 + 3));
    ref_crc = crc_div(bq, 4'b1011);
    run_frame("clamp", 20, bq, {1'b0, ref_crc}, ref_crc, 1'b1);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
